bcd_conv_ctrl: RTL and testbench
================================

Name: bcd_conv_ctrl

Overview:
- Sequential controller that converts a BIN_W-bit unsigned binary word to DIGITS packed BCD digits using shift-and-add-3 (double dabble), one bit per clock.
- Covers input widths beyond the team's 4-bit combinational binary-to-BCD decoder. Sits between a binary producer and a display/BCD consumer.
- Valid/ready handshake on both sides.
- Its 4-bit results must match the existing decoder's mapping: 0..15 maps to 0x00..0x15.

Parameters:
- BIN_W, 8: binary input width. Range 4..16.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W − 1. A violation is an elaboration-time error.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  producer has a word on bin.
- in_ready  output  1  controller can accept a word.
- bin  input  BIN_W  unsigned binary operand.
- out_valid  output  1  bcd holds a completed result.
- out_ready  input  1  consumer accepts the result.
- bcd  output  4*DIGITS  packed BCD result. Digit 0 (units) is in [3:0].
- busy  output  1  high in CONV or DONE.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, bcd=0.
  - Internal shift register and bit counter are cleared.
  - rst overrides all other inputs.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch bin into the binary shift register, clear the BCD accumulator, set counter=BIN_W, go to CONV.
  - in_valid=0: stay in IDLE.
- CONV (one step per cycle, in_ready=0):
  - First, every accumulator digit ≥5 gets +3 (4-bit add, no carry between digits).
  - Then {accumulator, binary reg} shifts left by 1.
  - Counter decrements by 1.
  - After the step where the counter reaches 0: load bcd from the accumulator, go to DONE.
- DONE:
  - out_valid=1; bcd is stable and must not change while out_valid=1.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - Otherwise hold indefinitely (backpressure).
  - in_ready=0, so a new word cannot be accepted in the same cycle as the output handoff.
- Latency:
  - Acceptance edge E0. out_valid becomes visible after edge E0+BIN_W.
  - Minimum occupancy per word is BIN_W+2 cycles (accept, BIN_W steps, handoff).
- bcd register:
  - Written only on the CONV→DONE transition.
  - Holds its last value in IDLE and CONV; it is not cleared on handoff.
- in_valid while busy: ignored, no latch. bin may change freely after acceptance.
- Reset mid-CONV or mid-DONE: the conversion is discarded, IDLE next cycle, out_valid=0, bcd=0.
- Accumulator width is 4*DIGITS. No overflow is possible given the parameter constraint, and no digit ever exceeds 9 at DONE.
- Upper unused digits read 0.

Test Plan:
1. bin=0 accepted -> out_valid after exactly 8 cycles; bcd=12'h000; in_ready=0 until handoff.
2. bin=8'd255 -> bcd=12'h255. bin=8'd100 -> bcd=12'h100. bin=8'd9 -> bcd=12'h009.
3. Sweep 0..15 (BIN_W=8) -> bcd matches the 4-bit decoder (e.g. 10 -> 12'h010, 15 -> 12'h015). Also run exhaustive 0..255 against a reference model.
4. Backpressure: out_ready=0 for 20 cycles after out_valid -> bcd and out_valid held constant. in_valid pulses with bin=8'd77 during this window are ignored. out_ready=1 -> IDLE next cycle.
5. Reset mid-operation: rst=1 four cycles into conversion of 8'd200 -> next cycle IDLE, bcd=0, out_valid=0. A following bin=8'd42 converts to 12'h042.
6. Parameter variant: BIN_W=12, DIGITS=4, bin=12'd4095 -> bcd=16'h4095, out_valid 12 cycles after acceptance.

Source files
------------

// File: rtl/bcd_conv_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready handshakes on the producer and consumer sides.
module bcd_conv_ctrl #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  generate
    if (BIN_W < 4 || BIN_W > 16) begin : g_bad_bin_w
      $error("bcd_conv_ctrl: BIN_W must be in 4..16");
    end
    if (pow10(DIGITS) <= (longint'(1) << BIN_W) - 1) begin : g_bad_digits
      $error("bcd_conv_ctrl: DIGITS too small to hold 2^BIN_W-1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state, state_n;
  logic [BIN_W-1:0]   sreg, sreg_step;
  logic [ACC_W-1:0]   acc, adj, acc_step;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   bcd_q;

  // Per-digit +3 correction, no carry between digits, then one joint shift.
  always_comb begin
    for (int d = 0; d < DIGITS; d++) begin
      adj[4*d +: 4] = (acc[4*d +: 4] >= 4'd5) ? acc[4*d +: 4] + 4'd3
                                              : acc[4*d +: 4];
    end
    {acc_step, sreg_step} = {adj, sreg} << 1;
  end

  // NOTE: next state is defaulted to the current state first so that
  // every path assigns it and no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)             state_n = CONV;
      CONV:    if (cnt == CNT_W'(1))     state_n = DONE;
      DONE:    if (out_ready)            state_n = IDLE;
      default:                           state_n = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sreg <= bin;
          acc  <= '0;
          cnt  <= CNT_W'(BIN_W);
        end
        CONV: begin
          sreg <= sreg_step;
          acc  <= acc_step;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) bcd_q <= acc_step;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Self-checking bench for bcd_conv_ctrl: decimal-arithmetic reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_bcd_conv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [7:0]  bin;
  logic        in_ready, out_valid, busy;
  logic [11:0] bcd;

  logic        in_valid2, out_ready2;
  logic [11:0] bin2;
  logic        in_ready2, out_valid2, busy2;
  logic [15:0] bcd2;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_conv_ctrl #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .busy(busy)
  );

  bcd_conv_ctrl #(.BIN_W(12), .DIGITS(4)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .bin(bin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .bcd(bcd2), .busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits via division, independent of the shift algorithm.
  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    int p = 1;
    for (int i = 0; i < 8; i++) begin
      r |= 32'((v / p) % 10) << (4 * i);
      p *= 10;
    end
    return r;
  endfunction

  // Transaction-level model of the 8-bit instance: phase 0 idle, 1 busy
  // converting, 2 result offered; result appears 8 edges after acceptance.
  int          m_ph, m_cnt, m_val;
  logic [11:0] m_bcd;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_cnt = 0; m_bcd = '0;
    end else begin
      case (m_ph)
        0: if (in_valid) begin m_val = int'(bin); m_cnt = 8; m_ph = 1; end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin m_bcd = to_bcd(m_val)[11:0]; m_ph = 2; end
        end
        default: if (out_ready) m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_in_ready",  {31'd0, in_ready},  {31'd0, m_ph == 0});
      check("model_out_valid", {31'd0, out_valid}, {31'd0, m_ph == 2});
      check("model_busy",      {31'd0, busy},      {31'd0, m_ph != 0});
      check("model_bcd",       {20'd0, bcd},       {20'd0, m_bcd});
    end
  end

  // Starts just after a negedge with the 8-bit DUT idle.
  task automatic convert(input int v, input logic [11:0] exp,
                         input int hold, input bit pulse77);
    int n = 0;
    in_valid = 1'b1;
    bin      = 8'(v);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    while (!out_valid && n <= 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 32'd8);
    check("bcd_value", {20'd0, bcd}, {20'd0, exp});
    for (int i = 0; i < hold; i++) begin
      if (pulse77) begin
        in_valid = ~in_valid;
        bin      = 8'd77;
      end
      @(negedge clk);
      check("hold_bcd",   {20'd0, bcd}, {20'd0, exp});
      check("hold_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff_in_ready",  {31'd0, in_ready},  32'd1);
    check("handoff_out_valid", {31'd0, out_valid}, 32'd0);
    check("handoff_bcd_kept",  {20'd0, bcd}, {20'd0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bin = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; bin2 = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy",      {31'd0, busy},      32'd0);
    check("reset_bcd",       {20'd0, bcd},       32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Model pins against hand-computed literals.
    check("model_pin_255", to_bcd(255),  32'h255);
    check("model_pin_4095", to_bcd(4095), 32'h4095);

    convert(0,   12'h000, 0, 1'b0);
    convert(255, 12'h255, 0, 1'b0);
    convert(100, 12'h100, 0, 1'b0);
    convert(9,   12'h009, 0, 1'b0);

    // 4-bit decoder mapping: 10..15 -> 0x10..0x15.
    for (int v = 0; v < 16; v++)
      convert(v, 12'((v < 10) ? v : v + 6), 0, 1'b0);

    convert(123, 12'h123, 20, 1'b1);

    // Reset four cycles into a conversion.
    in_valid = 1'b1; bin = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    check("midrst_bcd",       {20'd0, bcd},       32'd0);
    convert(42, 12'h042, 0, 1'b0);

    for (int v = 0; v < 256; v++)
      convert(v, to_bcd(v)[11:0], 0, 1'b0);

    // 12-bit / 4-digit variant.
    in_valid2 = 1'b1; bin2 = 12'd4095;
    @(negedge clk);
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n <= 40) begin
      @(negedge clk);
      n++;
    end
    check("w12_latency", n, 32'd12);
    check("w12_bcd", {16'd0, bcd2}, 32'h4095);
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    check("w12_handoff", {31'd0, out_valid2}, 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
